// File: rtl/cpu_io_bridge.sv
// Z80 I/O window decoder and strobe filter that turns each host cycle into one VDP request.
// Waits for ack with timeout; read data is held on cd_out until the next read completes.
module cpu_io_bridge #(
    parameter logic [7:0] BASE_ADDR   = 8'h98,
    parameter int         PORT_BITS   = 2,
    parameter int         FILTER_LEN  = 3,
    parameter int         ACK_TIMEOUT = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 iorq_n,
    input  logic                 rd_n,
    input  logic                 wr_n,
    input  logic [7:0]           addr,
    input  logic [7:0]           cd_in,
    output logic [7:0]           cd_out,
    output logic                 cd_oe,
    output logic                 cs_n,
    output logic                 req,
    output logic                 wrt,
    output logic [PORT_BITS-1:0] adr,
    output logic [7:0]           dbo,
    input  logic [7:0]           dbi,
    input  logic                 ack,
    output logic                 timeout,
    output logic                 conflict
);

    localparam logic [3:0] FL_LAST = 4'(FILTER_LEN - 1);
    localparam logic [7:0] TO_LAST = 8'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {RESYNC, IDLE, WAIT, HOLD} state_t;

    state_t               state;
    state_t               state_nxt;
    logic                 hit;
    logic                 rs_raw;
    logic                 ws_raw;
    logic [1:0]           str_s1;
    logic [1:0]           str_s2;
    logic [1:0]           filt;
    logic [3:0]           fcnt [2];
    logic [PORT_BITS-1:0] adr_s1;
    logic [PORT_BITS-1:0] adr_s2;
    logic [7:0]           cd_s1;
    logic [7:0]           cd_s2;
    logic [3:0]           rcnt;
    logic [7:0]           tcnt;
    logic                 do_req;
    logic                 do_done;
    logic                 do_to;
    logic                 do_cf;

    assign hit    = (addr[7:PORT_BITS] == BASE_ADDR[7:PORT_BITS]);
    assign cs_n   = ~(hit & ~iorq_n);
    assign cd_oe  = hit & ~iorq_n & ~rd_n;
    assign rs_raw = hit & ~iorq_n & ~rd_n;
    assign ws_raw = hit & ~iorq_n & ~wr_n;

    // Bit 0 carries the read strobe, bit 1 the write strobe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            str_s1  <= '0;
            str_s2  <= '0;
            filt    <= '0;
            fcnt[0] <= '0;
            fcnt[1] <= '0;
            adr_s1  <= '0;
            adr_s2  <= '0;
            cd_s1   <= '0;
            cd_s2   <= '0;
        end else begin
            str_s1 <= {ws_raw, rs_raw};
            str_s2 <= str_s1;
            adr_s1 <= addr[PORT_BITS-1:0];
            adr_s2 <= adr_s1;
            cd_s1  <= cd_in;
            cd_s2  <= cd_s1;
            for (int i = 0; i < 2; i++) begin
                if (str_s2[i] == filt[i]) begin
                    fcnt[i] <= '0;
                end else if (fcnt[i] == FL_LAST) begin
                    filt[i] <= ~filt[i];
                    fcnt[i] <= '0;
                end else begin
                    fcnt[i] <= fcnt[i] + 4'd1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        do_req    = 1'b0;
        do_done   = 1'b0;
        do_to     = 1'b0;
        do_cf     = 1'b0;
        case (state)
            RESYNC: begin
                // A cycle already in progress at reset release must end before we serve anything.
                if (str_s2 == 2'b00 && rcnt == FL_LAST) state_nxt = IDLE;
            end
            IDLE: begin
                if (filt == 2'b11) begin
                    do_cf     = 1'b1;
                    state_nxt = HOLD;
                end else if (filt != 2'b00) begin
                    do_req    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (ack) begin
                    do_done   = 1'b1;
                    state_nxt = HOLD;
                end else if (tcnt == TO_LAST) begin
                    do_to     = 1'b1;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (filt == 2'b00) state_nxt = IDLE;
            end
            default: state_nxt = RESYNC;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= RESYNC;
            rcnt     <= '0;
            tcnt     <= '0;
            req      <= 1'b0;
            wrt      <= 1'b0;
            adr      <= '0;
            dbo      <= 8'h00;
            cd_out   <= 8'hFF;
            timeout  <= 1'b0;
            conflict <= 1'b0;
        end else begin
            state <= state_nxt;
            req   <= do_req;
            if (state == RESYNC && str_s2 == 2'b00) rcnt <= rcnt + 4'd1;
            else                                    rcnt <= '0;
            if (do_req) begin
                tcnt <= '0;
                wrt  <= filt[1];
                adr  <= adr_s2;
                dbo  <= cd_s2;
            end else if (state == WAIT) begin
                tcnt <= tcnt + 8'd1;
            end
            if (do_done && !wrt) cd_out <= dbi;
            if (do_to) begin
                timeout <= 1'b1;
                if (!wrt) cd_out <= 8'hFF;
            end
            if (do_cf) conflict <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cpu_io_bridge.sv
// Two bridges share the host pins with disjoint windows ($98-$9B and $80-$87); requests are
// scoreboarded by a negedge monitor, completions and flags are checked by the host driver.
module tb_cpu_io_bridge;

    localparam int         FL    = 3;
    localparam int         AT    = 16;
    localparam logic [7:0] BASE0 = 8'h98;
    localparam logic [7:0] BASE1 = 8'h80;

    typedef struct {
        logic       w;
        logic [2:0] adr;
        logic [7:0] dbo;
        int         cyc;
    } exp_t;

    logic       clk    = 1'b0;
    logic       reset  = 1'b1;
    logic       iorq_n = 1'b1;
    logic       rd_n   = 1'b1;
    logic       wr_n   = 1'b1;
    logic [7:0] addr   = 8'h00;
    logic [7:0] cd_in  = 8'h00;
    logic [7:0] dbi    = 8'h00;
    logic       ack    = 1'b0;

    logic [7:0] cd_out0, cd_out1, dbo0, dbo1;
    logic       cd_oe0, cd_oe1, cs_n0, cs_n1, req0, req1, wrt0, wrt1;
    logic       timeout0, timeout1, conflict0, conflict1;
    logic [1:0] adr0;
    logic [2:0] adr1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    logic [7:0] exp_cd [2];
    logic       exp_to [2];
    logic       exp_cf [2];

    cpu_io_bridge dut0 (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .cd_in(cd_in), .cd_out(cd_out0), .cd_oe(cd_oe0), .cs_n(cs_n0),
        .req(req0), .wrt(wrt0), .adr(adr0), .dbo(dbo0), .dbi(dbi), .ack(ack),
        .timeout(timeout0), .conflict(conflict0)
    );

    cpu_io_bridge #(.BASE_ADDR(8'h80), .PORT_BITS(3)) dut1 (
        .clk(clk), .reset(reset), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
        .addr(addr), .cd_in(cd_in), .cd_out(cd_out1), .cd_oe(cd_oe1), .cs_n(cs_n1),
        .req(req1), .wrt(wrt1), .adr(adr1), .dbo(dbo1), .dbi(dbi), .ack(ack),
        .timeout(timeout1), .conflict(conflict1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] cdo_of(input int which);
        return (which == 0) ? cd_out0 : cd_out1;
    endfunction
    function automatic logic req_of(input int which);
        return (which == 0) ? req0 : req1;
    endfunction
    function automatic logic to_of(input int which);
        return (which == 0) ? timeout0 : timeout1;
    endfunction
    function automatic logic cf_of(input int which);
        return (which == 0) ? conflict0 : conflict1;
    endfunction

    // Request scoreboard: every req pulse must match the oldest expected transaction.
    always @(negedge clk) begin
        if (!reset) begin
            if (req0) begin
                check("req0_expected", 32'(q0.size() > 0), 1);
                if (q0.size() > 0) begin
                    e0 = q0.pop_front();
                    check("req0_wrt", wrt0, e0.w);
                    check("req0_adr", {1'b0, adr0}, e0.adr);
                    check("req0_dbo", dbo0, e0.dbo);
                    check("req0_cycle", cyc, e0.cyc);
                end
            end
            if (req1) begin
                check("req1_expected", 32'(q1.size() > 0), 1);
                if (q1.size() > 0) begin
                    e1 = q1.pop_front();
                    check("req1_wrt", wrt1, e1.w);
                    check("req1_adr", adr1, e1.adr);
                    check("req1_dbo", dbo1, e1.dbo);
                    check("req1_cycle", cyc, e1.cyc);
                end
            end
        end
    end

    task automatic push_exp(input int which, input logic [7:0] a, input logic w, input logic [7:0] d);
        exp_t e;
        e.w   = w;
        e.adr = (which == 0) ? 3'(a - BASE0) : 3'(a - BASE1);
        e.dbo = d;
        e.cyc = cyc + 2 + FL + 1;
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic wait_req(input int which);
        logic seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            @(posedge clk); #1;
            if (req_of(which)) seen = 1'b1;
        end
        check("req_seen", seen, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // ack_dly < 0 means the VDP never answers.
    task automatic host_cycle(input int which, input logic [7:0] a, input logic w,
                              input logic [7:0] d, input int ack_dly, input logic [7:0] rdat);
        int t0;
        addr   = a;
        cd_in  = d;
        iorq_n = 1'b0;
        if (w) wr_n = 1'b0;
        else   rd_n = 1'b0;
        t0 = cyc;
        push_exp(which, a, w, d);
        #1;
        check("cs_n_hit", (which == 0) ? cs_n0 : cs_n1, 0);
        check("cs_n_other", (which == 0) ? cs_n1 : cs_n0, 1);
        check("cd_oe", (which == 0) ? cd_oe0 : cd_oe1, !w);
        wait_req(which);
        if (ack_dly >= 0) begin
            repeat (ack_dly) @(posedge clk);
            #1;
            ack = 1'b1;
            dbi = rdat;
            @(posedge clk); #1;
            ack = 1'b0;
            dbi = 8'($urandom);
            if (!w) exp_cd[which] = rdat;
            check("cd_out_after_ack", cdo_of(which), exp_cd[which]);
            check("timeout_after_ack", to_of(which), exp_to[which]);
        end else begin
            for (int k = 1; k <= AT; k++) begin
                @(posedge clk); #1;
                if (k == AT - 1) check("timeout_early", to_of(which), exp_to[which]);
            end
            exp_to[which] = 1'b1;
            if (!w) exp_cd[which] = 8'hFF;
            check("timeout_set", to_of(which), exp_to[which]);
            check("cd_out_timeout", cdo_of(which), exp_cd[which]);
        end
        while (cyc < t0 + 20) begin
            @(posedge clk); #1;
        end
        iorq_n = 1'b1;
        rd_n   = 1'b1;
        wr_n   = 1'b1;
        idle(10);
        check("cd_out_held", cdo_of(which), exp_cd[which]);
        check("timeout_sticky", to_of(which), exp_to[which]);
        check("conflict_sticky", cf_of(which), exp_cf[which]);
    endtask

    task automatic clear_model();
        for (int i = 0; i < 2; i++) begin
            exp_cd[i] = 8'hFF;
            exp_to[i] = 1'b0;
            exp_cf[i] = 1'b0;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_req0", req0, 0);
        check("rst_wrt0", wrt0, 0);
        check("rst_adr0", adr0, 0);
        check("rst_dbo0", dbo0, 8'h00);
        check("rst_cd_out0", cd_out0, 8'hFF);
        check("rst_timeout0", timeout0, 0);
        check("rst_conflict0", conflict0, 0);
        check("rst_adr1", adr1, 0);
        check("rst_cd_out1", cd_out1, 8'hFF);
        check("rst_timeout1", timeout1, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at 1 ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clear_model();
        idle(3);
        check_reset_vals();
        reset = 1'b0;
        idle(8);

        host_cycle(0, 8'h99, 1'b1, 8'h5A, 2, 8'h00);
        host_cycle(0, 8'h9B, 1'b0, 8'h11, 3, 8'hC3);

        // Out-of-window access, then an in-window write pulse shorter than the filter.
        addr = 8'h9C; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        check("miss_cs_n0", cs_n0, 1);
        check("miss_cd_oe0", cd_oe0, 0);
        check("miss_cs_n1", cs_n1, 1);
        idle(15);
        iorq_n = 1'b1; rd_n = 1'b1;
        idle(10);
        addr = 8'h98; iorq_n = 1'b0; wr_n = 1'b0;
        idle(2);
        iorq_n = 1'b1; wr_n = 1'b1;
        idle(15);

        host_cycle(0, 8'h9A, 1'b0, 8'h00, -1, 8'h00);
        host_cycle(0, 8'h98, 1'b0, 8'h00, 1, 8'h3E);

        // Both strobes together, then release them one at a time.
        addr = 8'h98; iorq_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0;
        idle(15);
        exp_cf[0] = 1'b1;
        check("conflict_set", conflict0, exp_cf[0]);
        rd_n = 1'b1;
        idle(15);
        wr_n = 1'b1; iorq_n = 1'b1;
        idle(10);
        check("conflict_held", conflict0, exp_cf[0]);
        host_cycle(0, 8'h99, 1'b1, 8'hA5, 0, 8'h00);

        // Reset while waiting for ack, with the read strobe still held.
        addr = 8'h9A; cd_in = 8'h42; iorq_n = 1'b0; rd_n = 1'b0;
        push_exp(0, 8'h9A, 1'b0, 8'h42);
        wait_req(0);
        idle(3);
        reset = 1'b1;
        #1;
        clear_model();
        check_reset_vals();
        idle(1);
        reset = 1'b0;
        idle(20);
        check("post_reset_cd_out", cd_out0, exp_cd[0]);
        rd_n = 1'b1; iorq_n = 1'b1;
        idle(10);
        host_cycle(0, 8'h9B, 1'b0, 8'h07, 4, 8'h96);

        // Wider window at $80.
        addr = 8'h88; iorq_n = 1'b0; rd_n = 1'b0;
        #1;
        check("miss88_cs_n1", cs_n1, 1);
        check("miss88_cs_n0", cs_n0, 1);
        iorq_n = 1'b1; rd_n = 1'b1;
        idle(10);
        host_cycle(1, 8'h85, 1'b1, 8'h3C, 1, 8'h00);
        host_cycle(1, 8'h87, 1'b0, 8'h00, 4, 8'h77);
        host_cycle(1, 8'h83, 1'b0, 8'h00, AT - 1, 8'hE1);
        host_cycle(1, 8'h80, 1'b0, 8'h00, -1, 8'h00);

        for (int i = 0; i < 12; i++) begin
            int         which;
            int         off;
            int         dly;
            logic [7:0] a;
            which = $urandom_range(0, 1);
            off   = (which == 0) ? $urandom_range(0, 3) : $urandom_range(0, 7);
            a     = ((which == 0) ? BASE0 : BASE1) + 8'(off);
            dly   = int'($urandom_range(0, 15)) - 1;
            host_cycle(which, a, 1'($urandom_range(0, 1)), 8'($urandom), dly, 8'($urandom));
        end

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
